// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester channels, the shared-ALU port and the response channel.
// The slave modport is the arbiter; master is whatever surrounds it.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [3:0]  req0_op;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [3:0]  req1_op;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_res;
    logic        alu_v;
    logic        alu_z;
    logic        alu_n;
    logic        alu_c;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_res;
    logic [3:0]  rsp_flags;
    logic        rsp_err;

    logic        busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_res, alu_v, alu_z, alu_n, alu_c,
        output rsp_valid, rsp_id, rsp_res, rsp_flags, rsp_err,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_res, alu_v, alu_z, alu_n, alu_c,
        input  rsp_valid, rsp_id, rsp_res, rsp_flags, rsp_err,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single combinational ALU: grants one request,
// holds its operands on the ALU for one cycle, then presents the captured result.
module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   ptr;
    logic   grant0;
    logic   grant1;
    logic   accept;

    function automatic logic legal_op(input logic [3:0] op);
        case (op)
            4'b0000, 4'b1000, 4'b0001, 4'b0011, 4'b0010,
            4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111: legal_op = 1'b1;
            default:                                     legal_op = 1'b0;
        endcase
    endfunction

    // Grant is decoded from rst_n as well: state already reads IDLE during reset,
    // yet nothing may be accepted until reset is released.
    always_comb begin
        // NOTE: defaults first so every path assigns both grants and no latch is inferred.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && rst_n) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant1 = ptr;
                grant0 = ~ptr;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign accept         = grant0 | grant1;

    // NOTE: state and every registered output use non-blocking assignments so all
    // flops update together on the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= 1'b0;
            bus.busy      <= 1'b0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_op    <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_res   <= '0;
            bus.rsp_flags <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= EXEC;
                        bus.busy   <= 1'b1;
                        bus.alu_a  <= grant1 ? bus.req1_a  : bus.req0_a;
                        bus.alu_b  <= grant1 ? bus.req1_b  : bus.req0_b;
                        bus.alu_op <= grant1 ? bus.req1_op : bus.req0_op;
                        bus.rsp_id <= grant1;
                        // Priority passes to the requester that was not just served.
                        ptr        <= RR_EN ? ~grant1 : 1'b0;
                    end
                end
                EXEC: begin
                    state         <= RESP;
                    bus.rsp_valid <= 1'b1;
                    if (legal_op(bus.alu_op)) begin
                        bus.rsp_res   <= bus.alu_res;
                        bus.rsp_flags <= {bus.alu_v, bus.alu_z, bus.alu_n, bus.alu_c};
                        bus.rsp_err   <= 1'b0;
                    end else begin
                        bus.rsp_res   <= '0;
                        bus.rsp_flags <= '0;
                        bus.rsp_err   <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.busy      <= 1'b0;
                        bus.rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.busy      <= 1'b0;
                    bus.rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, meaning: 1 = round-robin grant, 0 = fixed priority with requester 0 always winning.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 reqN_ready  output  1  arbiter accepts requester N this cycle.
REQ-006 reqN_a, reqN_b  input  32 each  operands of requester N.
REQ-007 reqN_op  input  4  opcode of requester N.
REQ-008 alu_a, alu_b  output  32 each  operands driven to the shared ALU.
REQ-009 alu_op  output  4  opcode driven to the shared ALU.
REQ-010 alu_res  input  32  combinational ALU result.
REQ-011 alu_v, alu_z, alu_n, alu_c  input  1 each  combinational ALU flags.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer takes the response.
REQ-014 rsp_id  output  1  index of the requester that owns the response.
REQ-015 rsp_res  output  32  captured result.
REQ-016 rsp_flags  output  4  captured flags, ordered {v,z,n,c}.
REQ-017 rsp_err  output  1  opcode was not a legal ALU opcode.
REQ-018 busy  output  1  high whenever the state is not IDLE.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-020 IDLE→EXEC SHALL occur on any valid&ready transfer. EXEC→RESP SHALL always occur after one cycle. RESP→IDLE SHALL occur on rsp_valid&rsp_ready.
REQ-021 reqN_ready SHALL be high only in IDLE, only for the granted requester, and never for both requesters at once.
REQ-022 Grant SHALL be combinational in IDLE.
- If only one requester is valid, that requester is granted.
- If both are valid, the requester indicated by the priority pointer is granted.
REQ-023 With RR_EN=1, the pointer SHALL move to the other requester after each accepted transfer. With RR_EN=0, the pointer SHALL stay fixed at requester 0.
REQ-024 On acceptance, the requester's a, b, op and index SHALL be registered. The registered values SHALL drive alu_a, alu_b and alu_op until the next acceptance.
REQ-025 The legal opcodes SHALL be 0000 add, 1000 sub, 0001 sll, 0011 sltu, 0010 slt, 0100 xor, 0101 srl, 1101 sra, 0110 or and 0111 and. Every other opcode SHALL be illegal.
REQ-026 At the end of EXEC, alu_res and the flags SHALL be captured into rsp_res and rsp_flags, and rsp_err SHALL be set to 0.
REQ-027 For an illegal opcode, EXEC SHALL capture rsp_res=0, rsp_flags=0000 and rsp_err=1. The ALU output SHALL be ignored.
REQ-028 Latency: acceptance in cycle T SHALL give rsp_valid=1 in cycle T+2.
REQ-029 rsp_valid, rsp_id, rsp_res, rsp_flags and rsp_err SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-030 No new request SHALL be accepted before the response is consumed; there is one outstanding operation at most.
REQ-031 rsp_ready while rsp_valid=0 SHALL have no effect.
REQ-032 A requester dropping valid before acceptance SHALL lose nothing and SHALL not change the pointer.

Reset
REQ-033 While rst_n=0, with immediate (asynchronous) effect, the following SHALL hold:
- state=IDLE, pointer=requester 0;
- rsp_valid=0, rsp_id=0, rsp_res=0, rsp_flags=0000, rsp_err=0;
- alu_a=0, alu_b=0, alu_op=0000.
REQ-034 Reset during EXEC or RESP SHALL discard the operation in flight with no response issued. reqN_ready SHALL be 0 while rst_n=0.

Verification
REQ-035 req0 add, a=FFFFFFFF, b=00000001, accepted cycle T → rsp_valid at T+2 with rsp_id=0, rsp_res=00000000, rsp_flags z=1 and c=1.
REQ-036 RR_EN=1, both requesters continuously valid from reset with rsp_ready=1 → grants in order req0, req1, req0, req1; ready never high for both at once.
REQ-037 req1 op=1111 → rsp_err=1, rsp_res=00000000, rsp_flags=0000, rsp_id=1.
REQ-038 rsp_ready held low 3 cycles in RESP → outputs unchanged, both reqN_ready=0; accept resumes the cycle after the handshake.
REQ-039 rst_n low during EXEC → rsp_valid=0 immediately; after release the next grant with both valid goes to req0.
REQ-040 RR_EN=0, both requesters continuously valid → req0 granted every time and req1 never granted.
